// File: rtl/counter_ctrl_if.sv
// ============================================================================
// counter_ctrl_if : control/status bundle between button logic and counter_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

interface counter_ctrl_if #(
  parameter int LED_WIDTH = 4
);
  logic                 ce;
  logic                 start_stop;
  logic                 step;
  logic                 clear;
`ifdef COUNTER_CTRL_UPDOWN_EN
  logic                 dir;
`endif
  logic [LED_WIDTH-1:0] leds;
  logic                 tick;
  logic                 running;

  modport master (
`ifdef COUNTER_CTRL_UPDOWN_EN
    output dir,
`endif
    output ce, start_stop, step, clear,
    input  leds, tick, running
  );

  modport slave (
`ifdef COUNTER_CTRL_UPDOWN_EN
    input  dir,
`endif
    input  ce, start_stop, step, clear,
    output leds, tick, running
  );
endinterface

`default_nettype wire

// File: rtl/counter_ctrl.sv
// ============================================================================
// counter_ctrl : run/pause/step controller for the LED tick counter.
// Optional macro COUNTER_CTRL_UPDOWN_EN adds the dir (count-down) input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter_ctrl #(
  parameter int LED_WIDTH   = 4,
  parameter int TICK_CYCLES = 125_000_000
) (
  input  wire logic      clk,
  input  wire logic      rst,
  counter_ctrl_if.slave  bus
);
  localparam int DIV_WIDTH = $clog2(TICK_CYCLES + 1);
  localparam logic [DIV_WIDTH-1:0] c_div_last = DIV_WIDTH'(TICK_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] c_div_one  = DIV_WIDTH'(1);
  localparam logic [LED_WIDTH-1:0] c_led_one  = LED_WIDTH'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] w_div_nxt;
  logic [LED_WIDTH-1:0] r_leds;
  logic [LED_WIDTH-1:0] w_leds_nxt;
  logic [LED_WIDTH-1:0] w_leds_upd;
  logic                 r_tick;
  logic                 w_tick_nxt;
  logic                 r_running;
  logic                 w_running_nxt;

`ifdef COUNTER_CTRL_UPDOWN_EN
  assign w_leds_upd = bus.dir ? (r_leds - c_led_one) : (r_leds + c_led_one);
`else
  assign w_leds_upd = r_leds + c_led_one;
`endif

  always_ff @(posedge clk or posedge rst) begin : p_state_reg
    if (rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_leds    <= '0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_leds    <= w_leds_nxt;
      r_tick    <= w_tick_nxt;
      r_running <= w_running_nxt;
    end
  end

  // clear beats start_stop; step never changes state
  always_comb begin : p_next_state
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
    end else if (bus.start_stop) begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_PAUSE;
        S_PAUSE: w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A start_stop edge never advances the divider, so pause freezes div as-is
  always_comb begin : p_outputs
    w_div_nxt     = r_div;
    w_leds_nxt    = r_leds;
    w_tick_nxt    = 1'b0;
    w_running_nxt = (w_state_nxt == S_RUN);
    if (bus.clear) begin
      w_div_nxt  = '0;
      w_leds_nxt = '0;
    end else if (bus.start_stop) begin
      if (r_state == S_IDLE) begin
        w_div_nxt = '0;
      end
    end else if (r_state == S_RUN) begin
      if (bus.ce) begin
        if (r_div == c_div_last) begin
          w_div_nxt  = '0;
          w_leds_nxt = w_leds_upd;
          w_tick_nxt = 1'b1;
        end else begin
          w_div_nxt = r_div + c_div_one;
        end
      end
    end else if (bus.step) begin
      w_leds_nxt = w_leds_upd;
      w_tick_nxt = 1'b1;
    end
  end

  assign bus.leds    = r_leds;
  assign bus.tick    = r_tick;
  assign bus.running = r_running;
endmodule

`default_nettype wire

// File: tb/tb_counter_ctrl.sv
// ============================================================================
// tb_counter_ctrl : scoreboard bench for counter_ctrl (TICK_CYCLES=4, LED_WIDTH=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_counter_ctrl;
  localparam int TICKS = 4;

  typedef struct packed {
    logic [3:0] leds;
    logic       tick;
    logic       running;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;
  bit   done   = 1'b0;
  exp_t sb[$];

  // reference: mode 0 idle, 1 run, 2 pause
  int m_mode  = 0;
  int m_phase = 0;
  int m_leds  = 0;
  bit m_tick  = 1'b0;

  counter_ctrl_if #(.LED_WIDTH(4)) bus ();

  counter_ctrl #(.LED_WIDTH(4), .TICK_CYCLES(TICKS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int bump(input int v, input bit down);
`ifdef COUNTER_CTRL_UPDOWN_EN
    if (down) return (v + 15) % 16;
`endif
    return (v + 1) % 16;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_leds = 0; m_tick = 1'b0;
  endtask

  task automatic model_cycle(input bit c, ss, st, e, d);
    m_tick = 1'b0;
    if (c) begin
      m_mode = 0; m_phase = 0; m_leds = 0;
    end else if (ss) begin
      if (m_mode == 0) m_phase = 0;
      m_mode = (m_mode == 1) ? 2 : 1;
    end else if (m_mode == 1) begin
      if (e) begin
        m_phase++;
        if (m_phase == TICKS) begin
          m_phase = 0;
          m_leds  = bump(m_leds, d);
          m_tick  = 1'b1;
        end
      end
    end else if (st) begin
      m_leds = bump(m_leds, d);
      m_tick = 1'b1;
    end
  endtask

  task automatic drive(input bit r, c, ss, st, e, d);
    exp_t x;
    @(negedge clk);
    rst            = r;
    bus.clear      = c;
    bus.start_stop = ss;
    bus.step       = st;
    bus.ce         = e;
`ifdef COUNTER_CTRL_UPDOWN_EN
    bus.dir        = d;
`endif
    if (r) model_reset();
    else   model_cycle(c, ss, st, e, d);
    x.leds    = 4'(m_leds);
    x.tick    = m_tick;
    x.running = (m_mode == 1);
    sb.push_back(x);
  endtask

  task automatic idle_cycles(input int n, input bit e);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, e, 0);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (bus.leds !== 4'd0 || bus.tick !== 1'b0 || bus.running !== 1'b0) begin
      failed++;
      $display("FAIL %s actual leds=%0h tick=%b running=%b required all 0",
               name, bus.leds, bus.tick, bus.running);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (bus.leds !== e.leds || bus.tick !== e.tick || bus.running !== e.running) begin
          failed++;
          $display("FAIL outputs t=%0t actual leds=%0h tick=%b running=%b required leds=%0h tick=%b running=%b",
                   $time, bus.leds, bus.tick, bus.running, e.leds, e.tick, e.running);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    bus.clear = 1'b0; bus.start_stop = 1'b0; bus.step = 1'b0; bus.ce = 1'b0;
`ifdef COUNTER_CTRL_UPDOWN_EN
    bus.dir = 1'b0;
`endif
    #2;
    check_zero("reset_state");
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // run through a full LED wrap
    drive(0, 0, 1, 0, 1, 0);
    idle_cycles(70, 1'b1);

    // pause mid-period, hold, resume
    drive(0, 0, 1, 0, 1, 0);
    idle_cycles(2, 1'b1);
    drive(0, 0, 1, 0, 1, 0);
    idle_cycles(10, 1'b1);
    drive(0, 0, 1, 0, 1, 0);
    idle_cycles(6, 1'b1);

    // step behaviour in pause and run, combined pulses
    drive(0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 1, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    idle_cycles(5, 1'b1);

    // clear variants and async reset mid-run
    drive(0, 1, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 1, 0);
    idle_cycles(9, 1'b1);
    drive(0, 1, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 1, 0);
    idle_cycles(7, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("async_reset");
    drive(1, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 1, 0);

    // ce alternating, then held low
    for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, i[0], 0);
    idle_cycles(20, 1'b0);

    // count down from zero, then step down in pause
    drive(0, 1, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 1, 0, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 0, 1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)));
    end
    drive(0, 0, 0, 0, 0, 0);

    // drain the scoreboard, bounded
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain actual pending=%0d required 0", sb.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog actual timeout required completion");
      $fatal(1, "watchdog");
    end
  end
endmodule

`default_nettype wire
